// File: rtl/dlsc_pcie_s6_inbound_write_core.sv
// rtl/dlsc_pcie_s6_inbound_write_core.sv - inbound PCIe MWr TLPs to AXI write bursts
// Header FSM splits each TLP into boundary-aligned AW bursts; W data passes straight through.
module dlsc_pcie_s6_inbound_write_core #(
  parameter int ADDR = 32,
  parameter int LEN  = 4,
  parameter int MOT  = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic            tlp_h_ready,
  input  logic            tlp_h_valid,
  input  logic [ADDR-3:0] tlp_h_addr,
  input  logic [9:0]      tlp_h_len,
  input  logic [3:0]      tlp_h_be_first,
  input  logic [3:0]      tlp_h_be_last,
  output logic            tlp_d_ready,
  input  logic            tlp_d_valid,
  input  logic [31:0]     tlp_d_data,
  input  logic            axi_aw_ready,
  output logic            axi_aw_valid,
  output logic [ADDR-1:0] axi_aw_addr,
  output logic [LEN-1:0]  axi_aw_len,
  input  logic            axi_w_ready,
  output logic            axi_w_valid,
  output logic            axi_w_last,
  output logic [3:0]      axi_w_strb,
  output logic [31:0]     axi_w_data,
  output logic            axi_b_ready,
  input  logic            axi_b_valid,
  input  logic [1:0]      axi_b_resp,
  output logic            err,
  output logic            idle
);

  localparam int OW = $clog2(MOT + 1);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SPLIT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [ADDR-3:0] addr_q, addr_d;
  logic [10:0]     rem_q, rem_d;
  logic [3:0]      bef_q, bef_d, bel_q, bel_d;
  logic            first_q, first_d;
  logic            aw_valid_q, aw_valid_d;
  logic [OW-1:0]   out_q, out_d;
  logic            err_q, err_d;
  logic [1:0]      wr_q, rd_q;
  logic [2:0]      cnt_q, cnt_d;
  logic [LEN-1:0]  beat_q;

  logic [LEN-1:0]  q_len   [4];
  logic            q_first [4];
  logic            q_last  [4];
  logic [3:0]      q_bef   [4];
  logic [3:0]      q_bel   [4];

  logic [10:0] room, beats;
  logic        aw_hs, w_hs, w_active, w_last, last_burst, push, pop;

  // Beats left before the next 2^LEN-beat boundary, clipped to what the TLP still needs.
  assign room       = 11'(2 ** LEN) - 11'(addr_q[LEN-1:0]);
  assign beats      = (rem_q < room) ? rem_q : room;
  assign last_burst = (beats == rem_q);
  assign aw_hs      = aw_valid_q && axi_aw_ready;
  assign w_active   = (cnt_q != 3'd0);
  assign w_last     = w_active && (beat_q == q_len[rd_q]);
  assign w_hs       = tlp_d_valid && axi_w_ready && w_active;
  assign push       = aw_hs;
  assign pop        = w_hs && w_last;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    bef_d   = bef_q;
    bel_d   = bel_q;
    first_d = first_q;
    if (state_q == ST_IDLE) begin
      if (tlp_h_valid) begin
        state_d = ST_SPLIT;
        addr_d  = tlp_h_addr;
        rem_d   = {(tlp_h_len == 10'd0), tlp_h_len};
        bef_d   = tlp_h_be_first;
        bel_d   = tlp_h_be_last;
        first_d = 1'b1;
      end
    end else if (aw_hs) begin
      addr_d  = addr_q + (ADDR-2)'(beats);
      rem_d   = rem_q - beats;
      first_d = 1'b0;
      if (last_burst) state_d = ST_IDLE;
    end

    out_d = out_q;
    if (aw_hs && !axi_b_valid) out_d = out_q + OW'(1);
    else if (!aw_hs && axi_b_valid && out_q != '0) out_d = out_q - OW'(1);

    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 3'd1;
    else if (!push && pop) cnt_d = cnt_q - 3'd1;

    // Evaluated on next-cycle values so a registered valid never has to be retracted.
    aw_valid_d = (state_d == ST_SPLIT) && (out_d < OW'(MOT)) && (cnt_d < 3'd4);
    err_d      = axi_b_valid && (axi_b_resp != 2'b00);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      bef_q      <= '0;
      bel_q      <= '0;
      first_q    <= 1'b0;
      aw_valid_q <= 1'b0;
      out_q      <= '0;
      err_q      <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      bef_q      <= bef_d;
      bel_q      <= bel_d;
      first_q    <= first_d;
      aw_valid_q <= aw_valid_d;
      out_q      <= out_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      if (push) wr_q <= wr_q + 2'd1;
      if (pop) rd_q <= rd_q + 2'd1;
      if (pop) beat_q <= '0;
      else if (w_hs) beat_q <= beat_q + LEN'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_len[wr_q]   <= LEN'(beats - 11'd1);
      q_first[wr_q] <= first_q;
      q_last[wr_q]  <= last_burst;
      q_bef[wr_q]   <= bef_q;
      q_bel[wr_q]   <= bel_q;
    end
  end

  assert property (@(posedge clk) disable iff (!rst) !(axi_b_valid && out_q == '0));

  assign tlp_h_ready  = (state_q == ST_IDLE);
  assign axi_aw_valid = aw_valid_q;
  assign axi_aw_addr  = {addr_q, 2'b00};
  assign axi_aw_len   = LEN'(beats - 11'd1);
  assign axi_w_valid  = tlp_d_valid && w_active;
  assign tlp_d_ready  = axi_w_ready && w_active;
  assign axi_w_last   = w_last;
  assign axi_w_data   = tlp_d_data;
  // A single-dword TLP takes be_first, so the first-beat rule is checked first.
  assign axi_w_strb   = (q_first[rd_q] && beat_q == '0) ? q_bef[rd_q] :
                        (q_last[rd_q] && w_last)        ? q_bel[rd_q] : 4'hF;
  assign axi_b_ready  = 1'b1;
  assign err          = err_q;
  assign idle         = (state_q == ST_IDLE) && (cnt_q == 3'd0) && (out_q == '0);

endmodule

// File: tb/tb_dlsc_pcie_s6_inbound_write_core.sv
// tb/tb_dlsc_pcie_s6_inbound_write_core.sv - scoreboard bench for the inbound write core
module tb_dlsc_pcie_s6_inbound_write_core;

  localparam int ADDR = 32;
  localparam int LEN  = 4;
  localparam int MOT  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            tlp_h_ready, tlp_h_valid;
  logic [ADDR-3:0] tlp_h_addr;
  logic [9:0]      tlp_h_len;
  logic [3:0]      tlp_h_be_first, tlp_h_be_last;
  logic            tlp_d_ready, tlp_d_valid;
  logic [31:0]     tlp_d_data;
  logic            axi_aw_ready, axi_aw_valid;
  logic [ADDR-1:0] axi_aw_addr;
  logic [LEN-1:0]  axi_aw_len;
  logic            axi_w_ready, axi_w_valid, axi_w_last;
  logic [3:0]      axi_w_strb;
  logic [31:0]     axi_w_data;
  logic            axi_b_ready, axi_b_valid;
  logic [1:0]      axi_b_resp;
  logic            err, idle;

  dlsc_pcie_s6_inbound_write_core #(.ADDR(ADDR), .LEN(LEN), .MOT(MOT)) dut (
    .clk(clk), .rst(rst),
    .tlp_h_ready(tlp_h_ready), .tlp_h_valid(tlp_h_valid), .tlp_h_addr(tlp_h_addr),
    .tlp_h_len(tlp_h_len), .tlp_h_be_first(tlp_h_be_first), .tlp_h_be_last(tlp_h_be_last),
    .tlp_d_ready(tlp_d_ready), .tlp_d_valid(tlp_d_valid), .tlp_d_data(tlp_d_data),
    .axi_aw_ready(axi_aw_ready), .axi_aw_valid(axi_aw_valid), .axi_aw_addr(axi_aw_addr),
    .axi_aw_len(axi_aw_len), .axi_w_ready(axi_w_ready), .axi_w_valid(axi_w_valid),
    .axi_w_last(axi_w_last), .axi_w_strb(axi_w_strb), .axi_w_data(axi_w_data),
    .axi_b_ready(axi_b_ready), .axi_b_valid(axi_b_valid), .axi_b_resp(axi_b_resp),
    .err(err), .idle(idle)
  );

  typedef struct packed { logic [31:0] addr; logic [LEN-1:0] len; } aw_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } w_t;

  aw_t         aw_q[$];
  w_t          w_q[$];
  logic [31:0] pay_q[$];

  int     n_chk = 0, n_fail = 0;
  int     aw_cnt = 0, b_issued = 0, b_limit = 0, tb_out = 0;
  longint aw_beats = 0, w_beats = 0;
  logic   exp_err = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: a burst ends at the TLP's last dword or at the last dword of a 2^LEN block.
  task automatic send_tlp(input logic [31:0] addr, input int len, input logic [3:0] bef, input logic [3:0] bel);
    int n, s;
    logic [31:0] a, d;
    logic [3:0] strb;
    logic last;
    bit ok;
    n = (len == 0) ? 1024 : len;
    s = 0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(4 * i);
      if (i == 0 || (a >> 2) % (1 << LEN) == 0) s = i;
      if (i == 0) strb = bef;
      else if (i == n - 1) strb = bel;
      else strb = 4'hF;
      last = (i == n - 1) || ((a >> 2) % (1 << LEN) == (1 << LEN) - 1);
      d = $urandom;
      pay_q.push_back(d);
      w_q.push_back({d, strb, last});
      if (last) aw_q.push_back({addr + 32'(4 * s), LEN'(i - s)});
    end
    @(posedge clk); #1;
    tlp_h_valid    = 1'b1;
    tlp_h_addr     = addr[31:2];
    tlp_h_len      = 10'(len);
    tlp_h_be_first = bef;
    tlp_h_be_last  = (n == 1) ? 4'h0 : bel;
    ok = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (tlp_h_ready) begin ok = 1'b1; break; end
    end
    chk("header_accept", ok, 1'b1);
    @(posedge clk); #1;
    tlp_h_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (idle && aw_q.size() == 0 && w_q.size() == 0 && pay_q.size() == 0) begin ok = 1'b1; break; end
    end
    chk(nm, ok, 1'b1);
  endtask

  task automatic check_reset(input string t);
    chk({t, "_h_ready"}, tlp_h_ready, 1'b1);
    chk({t, "_d_ready"}, tlp_d_ready, 1'b0);
    chk({t, "_aw_valid"}, axi_aw_valid, 1'b0);
    chk({t, "_w_valid"}, axi_w_valid, 1'b0);
    chk({t, "_w_last"}, axi_w_last, 1'b0);
    chk({t, "_b_ready"}, axi_b_ready, 1'b1);
    chk({t, "_err"}, err, 1'b0);
    chk({t, "_idle"}, idle, 1'b1);
  endtask

  // Monitor: handshakes are judged on the falling edge, where inputs are stable until the next rise.
  always @(negedge clk) begin
    if (!rst) begin
      aw_q.delete(); w_q.delete();
      tb_out = 0; aw_cnt = 0; aw_beats = 0; w_beats = 0; exp_err = 1'b0;
    end else begin
      if (err || exp_err) chk("err_pulse", err, exp_err);
      exp_err = axi_b_valid && (axi_b_resp != 2'b00);
      if (axi_aw_valid) chk("aw_within_mot", (tb_out < MOT), 1'b1);
      if (axi_w_valid && axi_w_ready) begin
        if (w_q.size() == 0) chk("w_unexpected", 1'b1, 1'b0);
        else chk("w_beat", {w_q.pop_front(), (w_beats < aw_beats)}, {axi_w_data, axi_w_strb, axi_w_last, 1'b1});
        w_beats++;
      end
      if (axi_aw_valid && axi_aw_ready) begin
        if (aw_q.size() == 0) chk("aw_unexpected", 1'b1, 1'b0);
        else chk("aw_burst", {axi_aw_addr, axi_aw_len}, aw_q.pop_front());
        aw_beats += longint'(axi_aw_len) + 1;
        aw_cnt++;
        tb_out++;
      end
      if (axi_b_valid) tb_out--;
    end
  end

  initial begin
    bit hs;
    tlp_d_valid = 1'b0;
    tlp_d_data  = '0;
    forever begin
      @(negedge clk);
      hs = rst && tlp_d_valid && tlp_d_ready;
      @(posedge clk); #1;
      if (!rst) begin
        pay_q.delete();
        tlp_d_valid = 1'b0;
      end else begin
        if (hs) void'(pay_q.pop_front());
        if (pay_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          tlp_d_valid = 1'b1;
          tlp_d_data  = pay_q[0];
        end else begin
          tlp_d_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    axi_aw_ready = 1'b0;
    axi_w_ready  = 1'b0;
    forever begin
      @(posedge clk); #1;
      axi_aw_ready = ($urandom_range(0, 3) != 0);
      axi_w_ready  = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    axi_b_valid = 1'b0;
    axi_b_resp  = 2'b00;
    forever begin
      @(posedge clk); #1;
      axi_b_valid = 1'b0;
      axi_b_resp  = 2'b00;
      if (!rst) begin
        b_issued = 0;
      end else if (aw_cnt > b_issued && b_issued < b_limit && $urandom_range(0, 1) == 1) begin
        axi_b_valid = 1'b1;
        axi_b_resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        b_issued++;
      end
    end
  end

  initial begin
    int c0;
    longint w0;
    bit ok;
    logic [31:0] ra;
    int rl;
    tlp_h_valid = 1'b0; tlp_h_addr = '0; tlp_h_len = '0;
    tlp_h_be_first = '0; tlp_h_be_last = '0;
    b_limit = 1 << 30;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b1;

    send_tlp(32'h0000_1000, 1, 4'h3, 4'h0);
    wait_idle("idle_single");
    send_tlp(32'h0000_1038, 20, 4'hE, 4'h7);
    wait_idle("idle_split3");

    c0 = aw_cnt;
    send_tlp(32'h0000_0000, 0, 4'hF, 4'hF);
    wait_idle("idle_len1024");
    chk("len1024_aw_count", 64'(aw_cnt - c0), 64'd64);

    for (int t = 0; t < 30; t++) begin
      ra = {$urandom_range(0, 32'h0FFF_FFFF), 2'b00};
      rl = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : $urandom_range(1, 80);
      send_tlp(ra, rl, 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)));
    end
    wait_idle("idle_random");

    b_limit = b_issued;
    c0 = aw_cnt;
    send_tlp(32'h0000_2000, 40, 4'hF, 4'hF);
    repeat (40) @(negedge clk);
    chk("mot_aw_count", 64'(aw_cnt - c0), 64'd2);
    chk("mot_aw_held", axi_aw_valid, 1'b0);
    b_limit = b_issued + 1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (axi_b_valid) begin ok = 1'b1; break; end
    end
    chk("mot_b_seen", ok, 1'b1);
    @(negedge clk);
    chk("mot_aw_resume", axi_aw_valid, 1'b1);
    b_limit = 1 << 30;
    wait_idle("idle_mot");

    w0 = w_beats;
    send_tlp(32'h0000_3000, 100, 4'hF, 4'hF);
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (w_beats >= w0 + 10) begin ok = 1'b1; break; end
    end
    chk("reset_traffic_started", ok, 1'b1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_reset("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    b_limit = 1 << 30;
    @(negedge clk);
    chk("idle_after_reset", idle, 1'b1);
    send_tlp(32'h0000_4010, 37, 4'h8, 4'h1);
    wait_idle("idle_post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
